// File: rtl/register_rst_sync_pkg.sv
// ============================================================================
// Module   : register_rst_sync_pkg
// Purpose  : Shared constants for the enable-gated register with sync reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package register_rst_sync_pkg;

  localparam int c_DEFAULT_WIDTH = 8;
  localparam int c_MAX_WIDTH     = 64;

endpackage : register_rst_sync_pkg

`default_nettype wire

// File: rtl/register_rst_sync_if.sv
// ============================================================================
// Module   : register_rst_sync_if
// Purpose  : Load-enable / data / registered-output bundle for the register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface register_rst_sync_if
  import register_rst_sync_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) ();

  logic             en;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  modport master (
    output en,
    output d,
    input  q
  );

  modport slave (
    input  en,
    input  d,
    output q
  );

endinterface : register_rst_sync_if

`default_nettype wire

// File: rtl/register_rst_sync.sv
// ============================================================================
// Module   : register_rst_sync
// Purpose  : Parameterised storage register, load enable, sync active-low rst.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_rst_sync
  import register_rst_sync_pkg::*;
#(
  parameter int                     WIDTH       = c_DEFAULT_WIDTH,
  parameter logic [c_MAX_WIDTH-1:0] RESET_VALUE = '0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  register_rst_sync_if.slave    bus
);

  generate
    if ((WIDTH < 1) || (WIDTH > c_MAX_WIDTH)) begin : g_width_check
      $error("register_rst_sync: WIDTH must be in 1..64");
    end
  endgenerate

  // Oversized reset values keep only their low WIDTH bits.
  localparam logic [WIDTH-1:0] c_RESET = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= c_RESET;
    end else if (bus.en) begin
      r_q <= bus.d;
    end
  end

  assign bus.q = r_q;

endmodule : register_rst_sync

`default_nettype wire

// File: tb/tb_register_rst_sync.sv
// ============================================================================
// Module   : tb_register_rst_sync
// Purpose  : Self-checking bench for register_rst_sync at WIDTH 8, 1 and 32.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_rst_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] d;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  register_rst_sync_if #(.WIDTH(8))  if8  ();
  register_rst_sync_if #(.WIDTH(1))  if1  ();
  register_rst_sync_if #(.WIDTH(32)) if32 ();

  assign if8.en  = en;
  assign if8.d   = d[7:0];
  assign if1.en  = en;
  assign if1.d   = d[0:0];
  assign if32.en = en;
  assign if32.d  = d;

  register_rst_sync #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  register_rst_sync #(.WIDTH(1), .RESET_VALUE(64'hDEADBEEF)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  register_rst_sync #(.WIDTH(32), .RESET_VALUE(64'hDEADBEEF)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (if32.slave)
  );

  // Reference: value a register of width w must hold after one edge.
  function automatic logic [63:0] next_val(input logic [63:0] prev, input logic r,
                                           input logic e, input logic [63:0] dd,
                                           input logic [63:0] rv, input int w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (r == 1'b0) return rv & mask;
    if (e == 1'b1) return dd & mask;
    return prev;
  endfunction

  logic [63:0] m8, m1, m32;
  logic        m_valid = 1'b0;

  always @(posedge clk) begin
    m8  <= next_val(m8,  rst, en, {32'd0, d}, 64'd0,          8);
    m1  <= next_val(m1,  rst, en, {32'd0, d}, 64'hDEADBEEF,   1);
    m32 <= next_val(m32, rst, en, {32'd0, d}, 64'hDEADBEEF,  32);
    if (rst == 1'b0) m_valid <= 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_q8",  {56'd0, if8.q},  m8);
      chk("model_q1",  {63'd0, if1.q},  m1);
      chk("model_q32", {32'd0, if32.q}, m32);
    end
  end

  task automatic cyc(input logic r, input logic e, input logic [31:0] dd);
    rst = r;
    en  = e;
    d   = dd;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b1;
    d   = 32'hAA;

    cyc(1'b0, 1'b1, 32'hAA);
    chk("reset_q8",  {56'd0, if8.q},  64'h00);
    chk("reset_q1",  {63'd0, if1.q},  64'h1);
    chk("reset_q32", {32'd0, if32.q}, 64'hDEADBEEF);
    cyc(1'b0, 1'b1, 32'hAA);
    chk("reset_hold_q8", {56'd0, if8.q}, 64'h00);

    cyc(1'b1, 1'b1, 32'd31);
    chk("load31_q8", {56'd0, if8.q}, 64'd31);
    cyc(1'b1, 1'b1, 32'd127);
    chk("load127_q8",  {56'd0, if8.q},  64'd127);
    chk("load127_q32", {32'd0, if32.q}, 64'd127);

    repeat (3) cyc(1'b1, 1'b0, 32'd12);
    chk("hold_q8", {56'd0, if8.q}, 64'd127);
    chk("hold_q1", {63'd0, if1.q}, 64'd1);
    cyc(1'b1, 1'b1, 32'd12);
    chk("reload12_q8", {56'd0, if8.q}, 64'd12);
    chk("reload12_q1", {63'd0, if1.q}, 64'd0);

    cyc(1'b0, 1'b1, 32'd100);
    chk("rst_prio_q8",  {56'd0, if8.q},  64'd0);
    chk("rst_prio_q32", {32'd0, if32.q}, 64'hDEADBEEF);
    cyc(1'b1, 1'b0, 32'd100);
    chk("rst_release_q8", {56'd0, if8.q}, 64'd0);

    cyc(1'b1, 1'b1, 32'd55);
    chk("load55_q8", {56'd0, if8.q}, 64'd55);
    // Reset pulse that never spans a rising edge.
    en  = 1'b0;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("glitch_now_q8", {56'd0, if8.q}, 64'd55);
    cyc(1'b1, 1'b0, 32'd99);
    chk("glitch_q8", {56'd0, if8.q}, 64'd55);
    cyc(1'b0, 1'b0, 32'd99);
    chk("rst_en0_q8",  {56'd0, if8.q},  64'd0);
    chk("rst_en0_q1",  {63'd0, if1.q},  64'd1);

    cyc(1'b1, 1'b1, 32'hCAFEF00D);
    chk("load_wide_q32", {32'd0, if32.q}, 64'hCAFEF00D);
    chk("load_wide_q8",  {56'd0, if8.q},  64'h0D);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(7) != 0) ? 1'b1 : 1'b0,
          $urandom_range(1) == 1 ? 1'b1 : 1'b0,
          $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_register_rst_sync

`default_nettype wire

// File: doc/register_rst_sync.md
Name: register_rst_sync

Overview:
- General-purpose parameterised storage register with load enable and synchronous active-low reset.
- Used wherever the datapath needs a clocked, enable-gated holding element, e.g. pipeline/holding registers and CPU/peripheral state.
- Single clock domain, no combinational path from d to q.

Parameters:
- WIDTH, 8, data width in bits of d and q; legal range 1..64.
- RESET_VALUE, 0 (WIDTH bits), value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock; all state changes on the rising edge only.
- rst  input  1  reset; one clock; reset is synchronous and active-low (rst = 0 resets on the next rising clk edge).
- en  input  1  load enable, active-high.
- d  input  WIDTH  data to load.
- q  output  WIDTH  registered value, driven directly from the flop (no output logic).

Behaviour:
- At each rising clk edge, evaluate in priority order:
  - rst == 0: q <= RESET_VALUE, regardless of en and d.
  - rst == 1 and en == 1: q <= d.
  - rst == 1 and en == 0: q holds its previous value.
- Latency: a load is visible on q exactly one edge after d/en are sampled. No same-cycle bypass.
- Reset has priority over en. Simultaneous rst=0 and en=1 yields RESET_VALUE. The d value presented in that cycle is discarded, not captured later.
- Reset is fully synchronous:
  - Assertion or deassertion of rst between edges has no effect on q until the next rising edge.
  - No asynchronous sensitivity to rst.
- Reset deassertion: the first edge with rst=1 behaves as a normal cycle. If en=1 at that edge, d loads immediately; no dead cycle.
- Before the first rising edge, q is undefined (X in simulation). The system must apply reset for at least one edge.
- X/Z on en while rst=1: simulation-only concern; RTL does not mask it.
- Changes to d while en=0 never propagate to q.
- en held high continuously: q tracks d with one-cycle delay.
- Static checks: WIDTH < 1 is an elaboration error. A RESET_VALUE wider than WIDTH is truncated to its low WIDTH bits.
- No other outputs, status flags or handshakes.

Decomposition:
- No shared package required. The block is self-contained.
- A single always block implementing the priority (reset, load, hold) is sufficient.
- No sub-module. Wider or banked uses instantiate multiple copies at the parent level.

Test Plan:
- Reset: rst=0 for 2 edges, en=1, d=8'hAA -> q=0 after first edge and stays 0 while rst=0.
- Load: rst=1, en=1, d=31 then d=127 on successive edges -> q=31, then q=127, each one edge after sampling.
- Hold: en=0, d=12 for 3 edges after q=127 -> q remains 127; re-assert en=1 with d=12 -> q=12 next edge.
- Reset priority: rst=0, en=1, d=100 at the same edge -> q=0; release rst=1 with en=0 -> q stays 0 (100 never captured).
- Sync check: pulse rst=0 low and back high entirely between two rising edges (glitch) -> q unchanged. rst=0 across an edge while en=0 -> q=0.
- Parameter sweep: WIDTH=1 and WIDTH=32 with RESET_VALUE=32'hDEADBEEF -> reset loads 1'b1 and 32'hDEADBEEF respectively. Load/hold as above.
